// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path.
// Holds the default datapath widths, the register count and the
// zero-register index, plus the request record used by write-back requesters.
package regfile_pkg;

  localparam int DATA_WIDTH    = 64;
  localparam int ADDRESS_WIDTH = 5;
  localparam int REGISTER_SIZE = 2 ** ADDRESS_WIDTH;
  localparam int REG_ZERO      = 0;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Round-robin arbiter with a one-hot grant.
// The search starts one past the last granted requester and wraps.
// After reset, requester 0 has first priority.
// No grant is issued while reset is high.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);
  import regfile_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] sel;
  logic             found;

  // pick the first valid requester at or after last_grant+1, wrapping
  always_comb begin
    int c;
    c       = 0;
    sel     = '0;
    found   = 1'b0;
    win_idx = '0;
    grant   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(last_grant) + 1 + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      sel = IDX_W'(c);
      if (!found && req[sel]) begin
        found   = 1'b1;
        win_idx = sel;
      end
    end
    if (reset) found = 1'b0;
    if (found) grant[win_idx] = 1'b1;
  end

  // remember the winner; reset points at the last requester so 0 goes first
  always_ff @(posedge clk) begin
    if (reset) last_grant <= IDX_W'(NUM_REQ - 1);
    else if (found) last_grant <= win_idx;
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the register file.
// It arbitrates NUM_REQ write-back requesters onto the single write port and
// drives the registered regfile write port (RegWrite/wa/wd).
// The optional scoreboard is enabled by the REGFILE_WB_SCOREBOARD_EN macro.
// When enabled, it tracks pending destinations, flags read-after-write hazards
// to decode, and raises a sticky wb_err on a write-back to a register that is
// not pending.
// When the macro is undefined, the scoreboard is absent and
// hazard1/hazard2/wb_err are held at 0.
module regfile_wb_sched #(
  parameter int DATA_WIDTH    = regfile_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH,
  parameter int NUM_REQ       = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  alloc_valid,
  input  logic [ADDRESS_WIDTH-1:0]              alloc_addr,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic                                  RegWrite,
  output logic [ADDRESS_WIDTH-1:0]              wa,
  output logic [DATA_WIDTH-1:0]                 wd,
  input  logic [ADDRESS_WIDTH-1:0]              ra1,
  input  logic [ADDRESS_WIDTH-1:0]              ra2,
  output logic                                  hazard1,
  output logic                                  hazard2,
  output logic                                  wb_err
);
  import regfile_pkg::*;

  localparam int NREGS = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(REG_ZERO);

  logic [NUM_REQ-1:0]       grant;
  logic                     any_grant;
  logic [ADDRESS_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0]    win_data;
  logic                     reg_write_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign any_grant = |grant;
  assign RegWrite  = reg_write_q;

  // one-hot select of the granted requester's destination and data
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_addr = win_addr | req_addr[i];
        win_data = win_data | req_data[i];
      end
    end
  end

  // write stage: x0 requests still load wa/wd but never assert the enable
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      wa          <= '0;
      wd          <= '0;
    end else if (any_grant) begin
      reg_write_q <= (win_addr != ZERO_ADDR);
      wa          <= win_addr;
      wd          <= win_data;
    end else begin
      reg_write_q <= 1'b0;
    end
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;
  logic             err_hit;

  // clear the register just written, then apply the allocation so set wins
  always_comb begin
    pending_next = pending;
    if (reg_write_q) pending_next[wa] = 1'b0;
    if (alloc_valid && alloc_addr != ZERO_ADDR) pending_next[alloc_addr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  // pending-write scoreboard
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else pending <= pending_next;
  end

  // a grant to a nonzero register that is neither pending nor being allocated now
  always_comb begin
    err_hit = any_grant && (win_addr != ZERO_ADDR) && !pending[win_addr] &&
              !(alloc_valid && alloc_addr == win_addr);
  end

  // sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) wb_err <= 1'b0;
    else if (err_hit) wb_err <= 1'b1;
  end

  // the regfile writes on negedge, so the register being written this cycle is already safe to read
  assign hazard1 = pending[ra1] & ~(reg_write_q & (wa == ra1));
  assign hazard2 = pending[ra2] & ~(reg_write_q & (wa == ra2));
`else
  logic unused_sb;
  assign unused_sb = ^{alloc_valid, alloc_addr, ra1, ra2};
  assign hazard1   = 1'b0;
  assign hazard2   = 1'b0;
  assign wb_err    = 1'b0;
`endif

endmodule
